mem_access_unit: RTL and testbench

- Load/store front end sitting directly upstream of CacheData, between the CPU execute stage and the cache port.
- Accepts byte, half-word and word load/store requests at arbitrary byte addresses.
- Converts each request into one word-aligned cache access (enable pulse, aligned address, lane-shifted data, byte write enables).
- Extracts and sign- or zero-extends load results, and rejects misaligned or illegal requests without touching the cache.

---
 rtl/mem_access_unit.sv | 207 ++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store front end: turns byte/half/word requests into one aligned cache access
// and extends load results. Define MEM_ACCESS_STATS_EN to add hierarchical statistics counters.
module mem_access_unit #(
  parameter int unsigned ADDRESS_BITWIDTH = 32,
  parameter int unsigned DATA_BITWIDTH    = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_write,
  input  logic [1:0]                  req_size,
  input  logic                        req_unsigned,
  input  logic [ADDRESS_BITWIDTH-1:0] req_address,
  input  logic [DATA_BITWIDTH-1:0]    req_wdata,
  output logic                        resp_valid,
  output logic [DATA_BITWIDTH-1:0]    resp_rdata,
  output logic                        resp_error,
  output logic                        c_enable,
  output logic [ADDRESS_BITWIDTH-1:0] c_address,
  output logic [DATA_BITWIDTH-1:0]    c_data_in,
  output logic [3:0]                  c_write_enable_bytes,
  input  logic [DATA_BITWIDTH-1:0]    c_data_out,
  input  logic                        c_data_out_ready,
  input  logic                        c_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_LOAD_WAIT,
    S_STORE_WAIT,
    S_DRAIN,
    S_ERR
  } state_t;

  state_t                      state_q, state_d;
  logic                        write_q, write_d;
  logic [1:0]                  size_q, size_d;
  logic                        unsigned_q, unsigned_d;
  logic [1:0]                  lane_q, lane_d;
  logic [ADDRESS_BITWIDTH-1:0] c_address_q, c_address_d;
  logic [DATA_BITWIDTH-1:0]    c_data_in_q, c_data_in_d;
  logic [3:0]                  c_we_q, c_we_d;
  logic                        resp_valid_q, resp_valid_d;
  logic [DATA_BITWIDTH-1:0]    resp_rdata_q, resp_rdata_d;
  logic                        resp_error_q, resp_error_d;

  logic                        accept;
  logic                        bad_req;
  logic [DATA_BITWIDTH-1:0]    lane_wdata;
  logic [3:0]                  lane_we;
  logic [DATA_BITWIDTH-1:0]    rd_shift;
  logic [DATA_BITWIDTH-1:0]    load_ext;

  assign req_ready            = (state_q == S_IDLE) && !c_busy;
  assign accept               = req_valid && req_ready;
  assign c_enable             = (state_q == S_ISSUE);
  assign c_address            = c_address_q;
  assign c_data_in            = c_data_in_q;
  assign c_write_enable_bytes = c_we_q;
  assign resp_valid           = resp_valid_q;
  assign resp_rdata           = resp_rdata_q;
  assign resp_error           = resp_error_q;

  // Request decode: alignment check and store lane placement.
  always_comb begin
    bad_req    = 1'b0;
    lane_wdata = '0;
    lane_we    = '0;
    case (req_size)
      2'b00: begin
        lane_wdata = {24'b0, req_wdata[7:0]} << {req_address[1:0], 3'b000};
        lane_we    = 4'b0001 << req_address[1:0];
      end
      2'b01: begin
        bad_req    = req_address[0];
        lane_wdata = {16'b0, req_wdata[15:0]} << {req_address[1], 4'b0000};
        lane_we    = 4'b0011 << {req_address[1], 1'b0};
      end
      2'b10: begin
        bad_req    = |req_address[1:0];
        lane_wdata = req_wdata;
        lane_we    = 4'b1111;
      end
      default: bad_req = 1'b1;
    endcase
  end

  // Load lane select and sign/zero extension.
  always_comb begin
    rd_shift = c_data_out >> {lane_q, 3'b000};
    case (size_q)
      2'b00:   load_ext = {{24{!unsigned_q && rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   load_ext = {{16{!unsigned_q && rd_shift[15]}}, rd_shift[15:0]};
      default: load_ext = c_data_out;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    size_d       = size_q;
    unsigned_d   = unsigned_q;
    lane_d       = lane_q;
    c_address_d  = c_address_q;
    c_data_in_d  = c_data_in_q;
    c_we_d       = c_we_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_error_d = resp_error_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          write_d    = req_write;
          size_d     = req_size;
          unsigned_d = req_unsigned;
          lane_d     = req_address[1:0];
          if (bad_req) begin
            // Error response is raised while in ERR so ready returns the cycle after it.
            state_d      = S_ERR;
            resp_valid_d = 1'b1;
            resp_error_d = 1'b1;
            resp_rdata_d = '0;
          end else begin
            state_d     = S_ISSUE;
            c_address_d = {req_address[ADDRESS_BITWIDTH-1:2], 2'b00};
            c_data_in_d = lane_wdata;
            c_we_d      = req_write ? lane_we : 4'b0000;
          end
        end
      end
      S_ISSUE: state_d = write_q ? S_STORE_WAIT : S_LOAD_WAIT;
      S_LOAD_WAIT: begin
        if (c_data_out_ready) begin
          state_d      = S_DRAIN;
          resp_valid_d = 1'b1;
          resp_error_d = 1'b0;
          resp_rdata_d = load_ext;
        end
      end
      S_STORE_WAIT: begin
        if (!c_busy) begin
          state_d      = S_IDLE;
          resp_valid_d = 1'b1;
          resp_error_d = 1'b0;
          resp_rdata_d = '0;
        end
      end
      S_DRAIN: begin
        if (!c_busy) state_d = S_IDLE;
      end
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      write_q      <= 1'b0;
      size_q       <= '0;
      unsigned_q   <= 1'b0;
      lane_q       <= '0;
      c_address_q  <= '0;
      c_data_in_q  <= '0;
      c_we_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      size_q       <= size_d;
      unsigned_q   <= unsigned_d;
      lane_q       <= lane_d;
      c_address_q  <= c_address_d;
      c_data_in_q  <= c_data_in_d;
      c_we_q       <= c_we_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_error_q <= resp_error_d;
    end
  end

`ifdef MEM_ACCESS_STATS_EN
  logic [31:0] stat_loads;
  logic [31:0] stat_stores;
  logic [31:0] stat_errors;
  logic [31:0] stat_stall_cycles;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_loads        <= '0;
      stat_stores       <= '0;
      stat_errors       <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (accept && bad_req)               stat_errors <= stat_errors + 32'd1;
      if (accept && !bad_req && req_write)  stat_stores <= stat_stores + 32'd1;
      if (accept && !bad_req && !req_write) stat_loads  <= stat_loads + 32'd1;
      if (req_valid && !req_ready)          stat_stall_cycles <= stat_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: vector table plus hand sequences, driven against a small
// behavioural cache with cold lines (miss = long busy, read data ready while still busy).
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_address;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        c_enable;
  logic [31:0] c_address;
  logic [31:0] c_data_in;
  logic [3:0]  c_write_enable_bytes;
  logic [31:0] c_data_out;
  logic        c_data_out_ready;
  logic        c_busy;

  mem_access_unit #(.ADDRESS_BITWIDTH(32), .DATA_BITWIDTH(32)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .req_valid            (req_valid),
    .req_ready            (req_ready),
    .req_write            (req_write),
    .req_size             (req_size),
    .req_unsigned         (req_unsigned),
    .req_address          (req_address),
    .req_wdata            (req_wdata),
    .resp_valid           (resp_valid),
    .resp_rdata           (resp_rdata),
    .resp_error           (resp_error),
    .c_enable             (c_enable),
    .c_address            (c_address),
    .c_data_in            (c_data_in),
    .c_write_enable_bytes (c_write_enable_bytes),
    .c_data_out           (c_data_out),
    .c_data_out_ready     (c_data_out_ready),
    .c_busy               (c_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural cache: hit = 2 busy cycles, miss = 6; load data ready before busy drops.
  logic [31:0] mem [0:63];
  logic [7:0]  line_v;
  logic [3:0]  cnt;
  logic        ld_op;
  logic        miss_op;

  always @(posedge clk) begin
    if (rst) begin
      c_busy           <= 1'b0;
      c_data_out_ready <= 1'b0;
      c_data_out       <= 32'h0;
      cnt              <= 4'd0;
      line_v           <= 8'h0;
      ld_op            <= 1'b0;
      miss_op          <= 1'b0;
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[0] <= 32'hB7C6A980;
      mem[8] <= 32'h0BADF00D;
    end else begin
      c_data_out_ready <= 1'b0;
      if (c_enable) begin
        c_busy  <= 1'b1;
        miss_op <= !line_v[c_address[7:5]];
        cnt     <= line_v[c_address[7:5]] ? 4'd2 : 4'd6;
        line_v[c_address[7:5]] <= 1'b1;
        ld_op   <= (c_write_enable_bytes == 4'b0000);
        c_data_out <= mem[c_address[7:2]];
        for (int k = 0; k < 4; k++)
          if (c_write_enable_bytes[k]) mem[c_address[7:2]][8*k +: 8] <= c_data_in[8*k +: 8];
      end else if (cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
        if (ld_op && cnt == (miss_op ? 4'd4 : 4'd2)) c_data_out_ready <= 1'b1;
        if (cnt == 4'd1) c_busy <= 1'b0;
      end
    end
  end

  typedef struct {
    logic        write;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [3:0]  exp_we;
    logic [31:0] exp_din;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   resp_cnt = 0;
  int   en_cnt = 0;
  logic [31:0] cap_addr;
  logic [31:0] cap_din;
  logic [3:0]  cap_we;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && c_enable) begin
      en_cnt++;
      cap_addr = c_address;
      cap_din  = c_data_in;
      cap_we   = c_write_enable_bytes;
    end
    if (!rst && resp_valid) begin
      exp_t e;
      resp_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got resp_valid=1 expected no response (t=%0t)", $time);
      end else begin
        e = sb.pop_front();
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_error", {31'b0, resp_error}, {31'b0, e.err});
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic drive(input vec_t v);
    req_valid    = 1'b1;
    req_write    = v.write;
    req_size     = v.size;
    req_unsigned = v.uns;
    req_address  = v.addr;
    req_wdata    = v.wdata;
  endtask

  task automatic do_req(input vec_t v);
    int n;
    int rb;
    int eb;
    wait_ready();
    rb = resp_cnt;
    eb = en_cnt;
    drive(v);
    sb.push_back('{rdata: v.exp_rdata, err: v.exp_err});
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (resp_cnt == rb && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("resp_count", resp_cnt - rb, 32'd1);
    chk("enable_count", en_cnt - eb, v.exp_err ? 32'd0 : 32'd1);
    if (!v.exp_err) begin
      chk("c_address", cap_addr, v.addr & 32'hFFFF_FFFC);
      chk("c_we", {28'b0, cap_we}, {28'b0, v.exp_we});
      if (v.write) chk("c_data_in", cap_din, v.exp_din);
    end
  endtask

  vec_t vecs[16];

  initial begin
    vec_t v;
    int   rb;
    int   eb;
    int   n;
    int   stalls;

    //              wr    size   uns   addr   wdata          rdata          err   we       din
    vecs[0]  = '{1'b0, 2'b00, 1'b0, 32'd0, 32'h0,        32'hFFFFFF80, 1'b0, 4'b0000, 32'h0};
    vecs[1]  = '{1'b0, 2'b00, 1'b1, 32'd1, 32'h0,        32'h000000A9, 1'b0, 4'b0000, 32'h0};
    vecs[2]  = '{1'b0, 2'b01, 1'b0, 32'd2, 32'h0,        32'hFFFFB7C6, 1'b0, 4'b0000, 32'h0};
    vecs[3]  = '{1'b0, 2'b01, 1'b1, 32'd2, 32'h0,        32'h0000B7C6, 1'b0, 4'b0000, 32'h0};
    vecs[4]  = '{1'b1, 2'b00, 1'b0, 32'd1, 32'h12345678, 32'h0,        1'b0, 4'b0010, 32'h00007800};
    vecs[5]  = '{1'b0, 2'b10, 1'b0, 32'd0, 32'h0,        32'hB7C67880, 1'b0, 4'b0000, 32'h0};
    vecs[6]  = '{1'b0, 2'b10, 1'b0, 32'd2, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0};
    vecs[7]  = '{1'b0, 2'b11, 1'b0, 32'd0, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0};
    vecs[8]  = '{1'b1, 2'b01, 1'b0, 32'd2, 32'h0000BEEF, 32'h0,        1'b0, 4'b1100, 32'hBEEF0000};
    vecs[9]  = '{1'b0, 2'b10, 1'b0, 32'd0, 32'h0,        32'hBEEF7880, 1'b0, 4'b0000, 32'h0};
    vecs[10] = '{1'b0, 2'b00, 1'b0, 32'd3, 32'h0,        32'hFFFFFFBE, 1'b0, 4'b0000, 32'h0};
    vecs[11] = '{1'b1, 2'b10, 1'b0, 32'd4, 32'hDEADBEEF, 32'h0,        1'b0, 4'b1111, 32'hDEADBEEF};
    vecs[12] = '{1'b0, 2'b01, 1'b1, 32'd6, 32'h0,        32'h0000DEAD, 1'b0, 4'b0000, 32'h0};
    vecs[13] = '{1'b0, 2'b01, 1'b0, 32'd4, 32'h0,        32'hFFFFBEEF, 1'b0, 4'b0000, 32'h0};
    vecs[14] = '{1'b1, 2'b01, 1'b0, 32'd1, 32'h0000AAAA, 32'h0,        1'b1, 4'b0000, 32'h0};
    vecs[15] = '{1'b0, 2'b00, 1'b1, 32'd7, 32'h0,        32'h000000DE, 1'b0, 4'b0000, 32'h0};

    rst = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_size = 2'b00;
    req_unsigned = 1'b0;
    req_address = 32'h0;
    req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_c_enable", {31'b0, c_enable}, 32'd0);
    chk("rst_c_address", c_address, 32'd0);
    chk("rst_c_we", {28'b0, c_write_enable_bytes}, 32'd0);

    for (int i = 0; i < 16; i++) do_req(vecs[i]);

    // Misaligned word: response during ERR, ready returns one cycle later.
    wait_ready();
    eb = en_cnt;
    v = '{1'b0, 2'b10, 1'b0, 32'd2, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0};
    drive(v);
    sb.push_back('{rdata: 32'h0, err: 1'b1});
    @(negedge clk);
    req_valid = 1'b0;
    chk("err_resp_valid", {31'b0, resp_valid}, 32'd1);
    chk("err_resp_error", {31'b0, resp_error}, 32'd1);
    chk("err_ready_low", {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    chk("err_ready_back", {31'b0, req_ready}, 32'd1);
    chk("err_resp_pulse", {31'b0, resp_valid}, 32'd0);
    chk("err_no_enable", en_cnt - eb, 32'd0);

    // Back-to-back loads: cold line @32 then line @0; second request stalls through DRAIN.
    wait_ready();
    rb = resp_cnt;
    eb = en_cnt;
    v = '{1'b0, 2'b10, 1'b0, 32'd32, 32'h0, 32'h0BADF00D, 1'b0, 4'b0000, 32'h0};
    drive(v);
    sb.push_back('{rdata: 32'h0BADF00D, err: 1'b0});
    @(negedge clk);
    v = '{1'b0, 2'b10, 1'b0, 32'd4, 32'h0, 32'hDEADBEEF, 1'b0, 4'b0000, 32'h0};
    drive(v);
    stalls = 0;
    while (!req_ready && stalls < 200) begin
      stalls++;
      @(negedge clk);
    end
    chk("b2b_stall_cycles", stalls, 32'd8);
    chk("b2b_busy_at_accept", {31'b0, c_busy}, 32'd0);
    sb.push_back('{rdata: 32'hDEADBEEF, err: 1'b0});
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (resp_cnt - rb < 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    chk("b2b_resp_count", resp_cnt - rb, 32'd2);
    chk("b2b_enable_count", en_cnt - eb, 32'd2);

    // Reset in LOAD_WAIT abandons the load with no response.
    wait_ready();
    rb = resp_cnt;
    v = '{1'b0, 2'b10, 1'b0, 32'd32, 32'h0, 32'h0, 1'b0, 4'b0000, 32'h0};
    drive(v);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstmid_issue", {31'b0, c_enable}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rstmid_c_enable", {31'b0, c_enable}, 32'd0);
    chk("rstmid_c_address", c_address, 32'd0);
    chk("rstmid_c_we", {28'b0, c_write_enable_bytes}, 32'd0);
    chk("rstmid_resp_rdata", resp_rdata, 32'd0);
    chk("rstmid_req_ready", {31'b0, req_ready}, 32'd1);
    repeat (10) @(negedge clk);
    chk("rstmid_no_resp", resp_cnt - rb, 32'd0);
    chk("sb_empty", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected $finish before time limit");
    $fatal(1);
  end

endmodule
